// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: keeps the last two good bytes as {previous, latest}.
// Define PS2_TIMEOUT_EN to abandon frames stalled longer than TIMEOUT_CYCLES.
module ps2_receiver #(
  parameter int TIMEOUT_CYCLES = 2500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] data,
  output logic        error,
  output logic        valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      r_state, w_stateNext;
  logic [1:0]  r_clkSync;
  logic [1:0]  r_dataSync;
  logic        r_clkPrev;
  logic        w_fe;
  logic        w_bit;
  logic        w_timeout;
  logic [2:0]  r_bitCnt, w_bitCntNext;
  logic [7:0]  r_shift, w_shiftNext;
  logic        r_parity, w_parityNext;
  logic [15:0] r_data, w_dataNext;
  logic        r_error, w_errorNext;
  logic        r_valid, w_validNext;

  // Synchronisers reset to the idle-high level so reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
      r_clkPrev  <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[0], ps2_clk};
      r_dataSync <= {r_dataSync[0], ps2_data};
      r_clkPrev  <= r_clkSync[1];
    end
  end

  assign w_fe  = r_clkPrev & ~r_clkSync[1];
  assign w_bit = r_dataSync[1];

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] r_timer, w_timerNext;

  assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1)) && !w_fe;

  always_comb begin
    w_timerNext = r_timer + 1'b1;
    if (r_state == S_IDLE || w_fe || w_timeout) begin
      w_timerNext = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else begin
      r_timer <= w_timerNext;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_bitCnt <= 3'd0;
      r_shift  <= 8'h00;
      r_parity <= 1'b0;
      r_data   <= 16'h0000;
      r_error  <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_bitCnt <= w_bitCntNext;
      r_shift  <= w_shiftNext;
      r_parity <= w_parityNext;
      r_data   <= w_dataNext;
      r_error  <= w_errorNext;
      r_valid  <= w_validNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_bitCntNext = r_bitCnt;
    w_shiftNext  = r_shift;
    w_parityNext = r_parity;
    w_dataNext   = r_data;
    w_errorNext  = r_error;
    w_validNext  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_fe) begin
          if (!w_bit) begin
            w_stateNext  = S_DATA;
            w_bitCntNext = 3'd0;
          end else begin
            w_errorNext = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_fe) begin
          w_shiftNext  = {w_bit, r_shift[7:1]};
          w_bitCntNext = r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) begin
            w_stateNext = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (w_fe) begin
          w_parityNext = w_bit;
          w_stateNext  = S_STOP;
        end
      end
      S_STOP: begin
        if (w_fe) begin
          w_stateNext = S_IDLE;
          // Odd parity: data bits plus parity bit must contain an odd number of ones.
          if (w_bit && (^{r_shift, r_parity})) begin
            w_dataNext  = {r_data[7:0], r_shift};
            w_validNext = 1'b1;
            w_errorNext = 1'b0;
          end else begin
            w_errorNext = 1'b1;
          end
        end
      end
      default: w_stateNext = S_IDLE;
    endcase

    if (w_timeout) begin
      w_stateNext  = S_IDLE;
      w_bitCntNext = 3'd0;
      w_shiftNext  = 8'h00;
      w_errorNext  = 1'b1;
    end
  end

  assign data  = r_data;
  assign error = r_error;
  assign valid = r_valid;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: directed frames, random good/bad frames,
// inactivity timeout (behaviour depends on PS2_TIMEOUT_EN) and mid-frame reset.
module tb_ps2_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] data;
  logic        error;
  logic        valid;

  int          checks = 0;
  int          failures = 0;
  int          validCount = 0;
  int          expValidCount = 0;
  logic [15:0] expData;
  logic        expErr;
  logic [7:0]  rb;
  int          kind;
  logic        rpar;
  logic        rstop;

  ps2_receiver #(.TIMEOUT_CYCLES(100)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data     (data),
    .error    (error),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  // Every valid pulse spans exactly one falling clk edge, so this counts pulses.
  always @(negedge clk) begin
    if (valid) validCount++;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference rule: stop must be 1 and data+parity must hold an odd count of ones.
  function automatic logic frameGood(input logic [7:0] b, input logic par, input logic stop);
    return stop && (($countones({b, par}) % 2) == 1);
  endfunction

  function automatic logic oddParity(input logic [7:0] b);
    return (($countones(b) % 2) == 0);
  endfunction

  // One PS/2 bit cell of 50 clk cycles; data changes while ps2_clk is high.
  task automatic ps2Bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (25) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  // Full frame; the stop-bit fall is traced edge by edge to check output latency.
  task automatic applyStimulus(input string tag, input logic [7:0] b,
                               input logic par, input logic stop);
    logic good;
    logic [15:0] prevData;
    logic prevErr;
    good     = frameGood(b, par, stop);
    prevData = expData;
    prevErr  = expErr;
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(b[i]);
    ps2Bit(par);
    @(negedge clk);
    ps2_data = stop;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput({tag, ":valid_early"}, {15'd0, valid}, 16'd0);
    checkOutput({tag, ":data_early"}, data, prevData);
    checkOutput({tag, ":error_early"}, {15'd0, error}, {15'd0, prevErr});
    if (good) begin
      expData = {expData[7:0], b};
      expErr  = 1'b0;
      expValidCount++;
    end else begin
      expErr = 1'b1;
    end
    @(posedge clk);
    #1;
    checkOutput({tag, ":valid"}, {15'd0, valid}, {15'd0, good});
    checkOutput({tag, ":data"}, data, expData);
    checkOutput({tag, ":error"}, {15'd0, error}, {15'd0, expErr});
    @(posedge clk);
    #1;
    checkOutput({tag, ":valid_end"}, {15'd0, valid}, 16'd0);
    repeat (20) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  initial begin
    expData = 16'h0000;
    expErr  = 1'b0;

    // Reset state, held and after release.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst:data", data, 16'h0000);
    checkOutput("rst:error", {15'd0, error}, 16'd0);
    checkOutput("rst:valid", {15'd0, valid}, 16'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rel:data", data, 16'h0000);
    checkOutput("rel:valid", {15'd0, valid}, 16'd0);

    // Directed frames: history, bad parity, recovery, bad stop.
    applyStimulus("good1C", 8'h1C, 1'b0, 1'b1);
    applyStimulus("goodF0", 8'hF0, 1'b1, 1'b1);
    applyStimulus("badPar", 8'h1C, 1'b1, 1'b1);
    applyStimulus("good32", 8'h32, 1'b0, 1'b1);
    applyStimulus("badStop", 8'h1C, 1'b0, 1'b0);
    applyStimulus("good5A", 8'h5A, 1'b1, 1'b1);

    // Lone ps2_clk fall with data high in IDLE is a bad start bit.
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    expErr = 1'b1;
    checkOutput("badStart:error", {15'd0, error}, 16'd1);
    checkOutput("badStart:valid", {15'd0, valid}, 16'd0);
    checkOutput("badStart:data", data, expData);
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (15) @(negedge clk);
    applyStimulus("afterStart", 8'hC3, oddParity(8'hC3), 1'b1);

    // Random frames with occasional parity or stop faults.
    for (int i = 0; i < 10; i++) begin
      rb    = 8'($urandom);
      kind  = int'($urandom_range(0, 3));
      rpar  = oddParity(rb) ^ (kind == 0);
      rstop = (kind != 1);
      applyStimulus("rand", rb, rpar, rstop);
    end

    // Stalled frame: start plus four data bits, then ps2_clk held high.
    applyStimulus("preTo", 8'hA5, 1'b1, 1'b1);
    ps2Bit(1'b0);
    for (int i = 0; i < 3; i++) ps2Bit(1'b1);
    @(negedge clk);
    ps2_data = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (99) @(posedge clk);
    #1;
    checkOutput("to:before", {15'd0, error}, 16'd0);
    @(posedge clk);
    #1;
`ifdef PS2_TIMEOUT_EN
    expErr = 1'b1;
    checkOutput("to:error", {15'd0, error}, 16'd1);
    checkOutput("to:data", data, expData);
    applyStimulus("afterTo", 8'h1C, 1'b0, 1'b1);
    checkOutput("afterTo:low", {8'd0, data[7:0]}, 16'h001C);
`else
    checkOutput("noTo:error", {15'd0, error}, 16'd0);
    repeat (300) @(posedge clk);
    #1;
    checkOutput("noTo:errorLate", {15'd0, error}, 16'd0);
    checkOutput("noTo:data", data, expData);
    rst_n = 1'b0;
    expData = 16'h0000;
    expErr  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
`endif

    // Mid-frame asynchronous reset after six bits, with error and data non-zero.
    applyStimulus("preRstGood", 8'h69, 1'b1, 1'b1);
    applyStimulus("preRstBad", 8'h77, 1'b0, 1'b0);
    ps2Bit(1'b0);
    for (int i = 0; i < 5; i++) ps2Bit(i[0]);
    #2;
    rst_n = 1'b0;
    #1;
    expData = 16'h0000;
    expErr  = 1'b0;
    checkOutput("midRst:data", data, 16'h0000);
    checkOutput("midRst:error", {15'd0, error}, 16'd0);
    checkOutput("midRst:valid", {15'd0, valid}, 16'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    applyStimulus("afterRst", 8'h5A, 1'b1, 1'b1);
    checkOutput("afterRst:word", data, 16'h005A);

    checkOutput("validCount", validCount[15:0], expValidCount[15:0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_receiver.md
# ps2_receiver

Deserialises the PS/2 device-to-host stream (ps2_clk/ps2_data) into bytes and keeps the last two received bytes as a 16-bit word. It also raises a frame-error flag. It sits directly upstream of the seven-segment hex driver:
- `data` drives that driver's 16-bit input.
- `error` drives its error input, which shows "ERR" while high.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 2500 — system-clock cycles of ps2_clk inactivity (no falling edge) mid-frame before the frame is abandoned. Only used with `PS2_TIMEOUT_EN`. Must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock pin; asynchronous, idle high.
- `ps2_data`  in  1  raw PS/2 data pin; asynchronous, idle high.
- `data`  out  16  {previous byte, latest byte}; updated only on a good frame.
- `error`  out  1  high after a bad/abandoned frame; cleared by the next good frame.
- `valid`  out  1  one-cycle pulse when `data` updates.

## Operation
- **Input synchronisation:** each pin passes through a 2-FF synchroniser, then a third "previous" register on the clock path.
  - A PS/2 falling edge `fe` is: previous == 1 and synchronised == 0.
  - Data is sampled from the synchronised ps2_data in the `fe` cycle.
- **Frame format:** 11 bits, LSB first: start (0), d0..d7, odd parity, stop (1).
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE:
    - On `fe` with start bit 0 → DATA, bit counter = 0.
    - On `fe` with start bit 1 → error = 1, stay IDLE.
  - DATA: on each `fe`, shift the bit into the byte register (LSB first) and increment a 3-bit counter. At counter == 7 → PARITY.
  - PARITY: on `fe`, store the parity bit → STOP.
  - STOP: on `fe`, the frame is good iff stop == 1 and XOR(d0..d7, parity) == 1. Always → IDLE.
    - Good frame: data ← {data[7:0], byte}, valid = 1 for one cycle, error ← 0.
    - Bad frame: error ← 1; data and valid unchanged.
- **Hold behaviour:**
  - `data` holds its value indefinitely between good frames.
  - `error` is sticky until a good frame completes or reset.
- **Host-to-device:** not supported; this block never drives the PS/2 pins.
- **Reset (asynchronous, any state, including mid-frame):**
  - state = IDLE, counter = 0, byte register = 0.
  - data = 16'h0000, error = 0, valid = 0.
  - Synchroniser and previous registers = 1, so no spurious `fe` occurs after reset release.
  - A partial frame in progress at reset is discarded; the receiver re-locks on the next start bit.

## Timing
- **Pin-to-output latency:** a ps2_clk fall that is set up before rising edge k:
  - is seen as `fe` in the cycle after edge k+1;
  - outputs (`data`, `valid`, `error`) change at edge k+2.
- **`valid`:** high for exactly one `clk` cycle per good frame. It coincides with the first cycle in which the new `data` is visible.
- **Error timing:**
  - `error` rises at the same edge a bad stop/parity/start is evaluated.
  - `error` falls at the same edge `valid` rises.
- **Clock ratio:** PS/2 clock is 10–16.7 kHz, so `clk` must be ≥ 40× faster. Back-to-back frames need no idle gap beyond the PS/2 stop bit.
- **Simultaneous events:** none possible. Exactly one `fe` is processed per cycle, and reset dominates everything.

## Configuration
- **`PS2_TIMEOUT_EN` defined:**
  - An inactivity counter (width ⌈log2 TIMEOUT_CYCLES⌉) is built.
  - The counter is held at 0 in IDLE and cleared on every `fe`. It increments each cycle in DATA/PARITY/STOP.
  - When it reaches TIMEOUT_CYCLES−1: state → IDLE, error ← 1, partial byte discarded, data unchanged, no `valid`.
- **Undefined:**
  - No counter is built and `TIMEOUT_CYCLES` is ignored.
  - A partial frame waits indefinitely for further `fe`s; only completion or reset returns the FSM to IDLE.

## Test plan
- **Good frame:** reset, then send byte 0x1C (parity 0, stop 1) → one `valid` pulse; data = 16'h001C; error = 0; pulse at edge k+2 after the stop-bit fall.
- **Two-byte history:** continue with 0xF0 (parity 1) → data = 16'h1CF0, second `valid` pulse.
- **Bad parity:**
  - Send 0x1C with parity 1 → error = 1, data stays 16'h1CF0, no `valid`.
  - Then send good 0x32 → error = 0, data = 16'hF032.
- **Bad stop bit / bad start bit:**
  - 0x1C with stop = 0 → error = 1, data unchanged.
  - A lone ps2_clk fall with ps2_data = 1 in IDLE → error = 1, state IDLE.
- **Timeout (with `PS2_TIMEOUT_EN`, TIMEOUT_CYCLES = 100):**
  - Send start plus 4 data bits, then hold ps2_clk high → error = 1 exactly 100 cycles after the last `fe`, FSM in IDLE.
  - A following good 0x1C → data low byte 0x1C, error = 0.
  - Without the macro, the same stimulus leaves error = 0 indefinitely.
- **Reset mid-frame:**
  - Assert rst_n = 0 after 6 bits → data = 0, error = 0, valid = 0 immediately (asynchronous).
  - After release, a good 0x5A → data = 16'h005A.
